bp_fe_realigner: RTL and testbench
==================================

BP_FE_REALIGNER -- requirements
Module: bp_fe_realigner

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg; selects the processor configuration, from which vaddr_width_p is derived.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-003 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port fetch_v_i, input, 1 bit: fetch word valid.
REQ-005 SHALL have port fetch_pc_i, input, vaddr_width_p bits: PC of the first parcel used; bit 1 selects the starting parcel, bit 0 is ignored.
REQ-006 SHALL have port fetch_data_i, input, 32 bits: the 4-byte-aligned fetch word containing that PC.
REQ-007 SHALL have port fetch_ready_o, output, 1 bit: word consumed when fetch_v_i & fetch_ready_o.
REQ-008 SHALL have port redirect_v_i, input, 1 bit: flush request.
REQ-009 SHALL have port instr_v_o, output, 1 bit: assembled instruction valid.
REQ-010 SHALL have port instr_o, output, 32 bits: instruction, consumed by the FE instruction scan stage.
REQ-011 SHALL have port instr_pc_o, output, vaddr_width_p bits: PC of instr_o.
REQ-012 SHALL have port instr_compressed_o, output, 1 bit: instr_o is a 16-bit parcel, zero-extended.
REQ-013 SHALL have port instr_ready_i, input, 1 bit: consumer accepts when instr_v_o & instr_ready_i.

Function
REQ-014 SHALL classify a 16-bit parcel as compressed iff bits [1:0] != 2'b11; L = fetch_data_i[15:0], H = fetch_data_i[31:16].
REQ-015 SHALL implement states E_EMPTY, E_HALF (holds the low parcel of a 32-bit instruction plus its PC) and E_PENDING (holds a compressed parcel plus its PC still to emit).
REQ-016 E_EMPTY, pc[1]=0, L full: SHALL emit {H,L} at pc and remain in E_EMPTY.
REQ-017 E_EMPTY, pc[1]=0, L compressed: SHALL emit L at pc, then go to E_PENDING if H is compressed, else to E_HALF, holding H at pc+2.
REQ-018 E_EMPTY, pc[1]=1: SHALL emit H at pc if H is compressed; otherwise it SHALL emit nothing, hold H at pc and go to E_HALF.
REQ-019 E_HALF with fetch_pc_i == held_pc+2: SHALL emit {L,held} at held_pc, then handle H exactly as in REQ-017.
REQ-020 E_HALF with fetch_pc_i != held_pc+2: SHALL discard the held parcel and process the word as in E_EMPTY, same cycle.
REQ-021 E_PENDING: SHALL drive instr_v_o=1 with the held parcel, keep fetch_ready_o=0, and go to E_EMPTY on the output handshake.
REQ-022 Outputs SHALL be combinational from state and inputs (zero latency); the word SHALL be consumed only if its emission, when any, handshakes in the same cycle: fetch_ready_o = (state != E_PENDING) & (instr_ready_i | no emission required).
REQ-023 State and hold registers SHALL update only on a consumed word or an E_PENDING handshake.
REQ-024 redirect_v_i SHALL force instr_v_o=0 and fetch_ready_o=0 that cycle and set E_EMPTY next cycle; this takes priority over all other events.
REQ-025 PC arithmetic SHALL be modulo 2^vaddr_width_p; held_pc+2 wraps.

Reset
REQ-026 Reset assertion SHALL asynchronously force E_EMPTY, hold registers to 0, instr_v_o=0 and fetch_ready_o=0 while asserted, including mid-instruction; a held half SHALL be lost.
REQ-027 After deassertion, the block SHALL first accept a word in E_EMPTY.

Configuration
REQ-028 Macro BP_FE_COMPRESSED_EN defined: behaviour per REQ-014..025.
REQ-029 Macro undefined: SHALL be a pass-through.
  - instr_o=fetch_data_i, instr_pc_o=fetch_pc_i, instr_compressed_o=0, fetch_ready_o=instr_ready_i.
  - Words with pc[1]=1 SHALL be consumed without emission.
  - No state registers.

Structure
REQ-030 SHALL place the state enum bp_fe_realigner_state_e and the parcel-compressed test in bp_fe_pkg; parcel width SHALL use c_instr_width_gp.
REQ-031 SHALL have no sub-module; hold registers are plain flops with async reset.

Verification
REQ-032 Word 0x00A00093 at pc 0x1000, E_EMPTY -> instr 0x00A00093, pc 0x1000, compressed=0, fetch_ready=1.
REQ-033 Word 0x45014501 at pc 0x1000 -> cycle 1 emit 0x4501 @0x1000 with word consumed; cycle 2 emit 0x4501 @0x1002 with fetch_ready_o=0; then E_EMPTY.
REQ-034 Word 0x00934501 @0x2000, then 0x000000A0 @0x2004 -> emit 0x4501 @0x2000, then 0x00A00093 @0x2002.
REQ-035 In E_HALF holding @0x2002, redirect_v_i=1, then word 0x00A00093 @0x3000 -> no output during redirect; then 0x00A00093 @0x3000.
REQ-036 instr_ready_i=0 for 3 cycles with fetch word valid -> fetch_ready_o=0 and outputs stable; word consumed on the first ready cycle.
REQ-037 reset_n_i low while in E_PENDING -> instr_v_o drops immediately; E_EMPTY after release.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Shared types and helpers for the BlackParrot front-end realigner: processor
// configuration, realigner state encoding and the 16-bit parcel classifier.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_sv48_cfg    = 2'd1
  } bp_params_e;

  localparam int instr_width_gp   = 32;
  localparam int c_instr_width_gp = 16;

  typedef enum logic [1:0] {
    E_EMPTY   = 2'd0,
    E_HALF    = 2'd1,
    E_PENDING = 2'd2
  } bp_fe_realigner_state_e;

  // Virtual address width implied by each processor configuration.
  function automatic int bp_vaddr_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      e_bp_sv48_cfg:    return 48;
      default:          return 39;
    endcase
  endfunction

  // A parcel is compressed unless its two low bits are both set.
  function automatic logic parcel_compressed_f(logic [c_instr_width_gp-1:0] parcel);
    return (parcel[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/bp_fe_realigner.sv
// Reassembles 16/32-bit RISC-V instructions from aligned 32-bit fetch words.
// BP_FE_COMPRESSED_EN enables the realigner; without it the block is a pass-through.
module bp_fe_realigner
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int vaddr_width_p = bp_vaddr_width_f(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic [31:0]              fetch_data_i,
  output logic                     fetch_ready_o,
  input  logic                     redirect_v_i,
  output logic                     instr_v_o,
  output logic [31:0]              instr_o,
  output logic [vaddr_width_p-1:0] instr_pc_o,
  output logic                     instr_compressed_o,
  input  logic                     instr_ready_i
);

  logic active_s;
  assign active_s = reset_n_i & ~redirect_v_i;

`ifdef BP_FE_COMPRESSED_EN

  localparam int pad_w = instr_width_gp - c_instr_width_gp;

  bp_fe_realigner_state_e        state_r, state_nxt_s;
  logic [c_instr_width_gp-1:0]   held_r, held_nxt_s;
  logic [vaddr_width_p-1:0]      held_pc_r, held_pc_nxt_s;

  logic                          emit_s;
  logic [31:0]                   emit_instr_s;
  logic [vaddr_width_p-1:0]      emit_pc_s;
  logic                          emit_c_s;

  logic [c_instr_width_gp-1:0]   lo_s, hi_s;
  logic                          lo_c_s, hi_c_s;
  logic [vaddr_width_p-1:0]      held_pc_inc_s, fetch_pc_inc_s;
  logic                          match_s;
  logic                          consume_s, pend_hs_s;

  assign lo_s           = fetch_data_i[c_instr_width_gp-1:0];
  assign hi_s           = fetch_data_i[31:c_instr_width_gp];
  assign lo_c_s         = parcel_compressed_f(lo_s);
  assign hi_c_s         = parcel_compressed_f(hi_s);
  assign held_pc_inc_s  = held_pc_r + vaddr_width_p'(2);
  assign fetch_pc_inc_s = fetch_pc_i + vaddr_width_p'(2);
  // Bit 0 of the PC carries no meaning, so continuity is judged on [W-1:1].
  assign match_s        = (state_r == E_HALF) &&
                          (fetch_pc_i[vaddr_width_p-1:1] == held_pc_inc_s[vaddr_width_p-1:1]);

  // Emission and next-state selection for the current state and fetch word.
  always_comb begin
    emit_s        = 1'b0;
    emit_instr_s  = 32'h0000_0000;
    emit_pc_s     = fetch_pc_i;
    emit_c_s      = 1'b0;
    state_nxt_s   = state_r;
    held_nxt_s    = held_r;
    held_pc_nxt_s = held_pc_r;
    case (state_r)
      E_PENDING: begin
        emit_s       = 1'b1;
        emit_instr_s = {{pad_w{1'b0}}, held_r};
        emit_pc_s    = held_pc_r;
        emit_c_s     = 1'b1;
        state_nxt_s  = E_EMPTY;
      end
      E_EMPTY, E_HALF: begin
        if (!fetch_v_i) begin
          state_nxt_s = state_r;
        end else if (match_s) begin
          emit_s        = 1'b1;
          emit_instr_s  = {lo_s, held_r};
          emit_pc_s     = held_pc_r;
          emit_c_s      = 1'b0;
          state_nxt_s   = hi_c_s ? E_PENDING : E_HALF;
          held_nxt_s    = hi_s;
          held_pc_nxt_s = fetch_pc_inc_s;
        end else if (!fetch_pc_i[1]) begin
          emit_s    = 1'b1;
          emit_pc_s = fetch_pc_i;
          if (lo_c_s) begin
            emit_instr_s  = {{pad_w{1'b0}}, lo_s};
            emit_c_s      = 1'b1;
            state_nxt_s   = hi_c_s ? E_PENDING : E_HALF;
            held_nxt_s    = hi_s;
            held_pc_nxt_s = fetch_pc_inc_s;
          end else begin
            emit_instr_s = fetch_data_i;
            emit_c_s     = 1'b0;
            state_nxt_s  = E_EMPTY;
          end
        end else begin
          // Upper-parcel start: a full instruction must wait for the next word.
          if (hi_c_s) begin
            emit_s       = 1'b1;
            emit_instr_s = {{pad_w{1'b0}}, hi_s};
            emit_pc_s    = fetch_pc_i;
            emit_c_s     = 1'b1;
            state_nxt_s  = E_EMPTY;
          end else begin
            emit_s        = 1'b0;
            state_nxt_s   = E_HALF;
            held_nxt_s    = hi_s;
            held_pc_nxt_s = fetch_pc_i;
          end
        end
      end
      default: begin
        state_nxt_s = E_EMPTY;
      end
    endcase
  end

  // Handshake-qualified outputs; reset and redirect silence both directions.
  always_comb begin
    instr_v_o          = active_s & emit_s;
    instr_o            = emit_instr_s;
    instr_pc_o         = emit_pc_s;
    instr_compressed_o = emit_c_s;
    fetch_ready_o      = active_s & (state_r != E_PENDING) & (instr_ready_i | ~emit_s);
  end

  assign consume_s = fetch_v_i & fetch_ready_o;
  assign pend_hs_s = (state_r == E_PENDING) & instr_v_o & instr_ready_i;

  // State and hold registers advance only on a consumed word or pending handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= E_EMPTY;
      held_r    <= '0;
      held_pc_r <= '0;
    end else if (redirect_v_i) begin
      state_r   <= E_EMPTY;
      held_r    <= '0;
      held_pc_r <= '0;
    end else if (consume_s || pend_hs_s) begin
      state_r   <= state_nxt_s;
      held_r    <= held_nxt_s;
      held_pc_r <= held_pc_nxt_s;
    end
  end

`else

  logic unused_s;
  assign unused_s = clk_i;

  // Pass-through: upper-parcel words are swallowed without an emission.
  always_comb begin
    instr_v_o          = active_s & fetch_v_i & ~fetch_pc_i[1];
    instr_o            = fetch_data_i;
    instr_pc_o         = fetch_pc_i;
    instr_compressed_o = 1'b0;
    fetch_ready_o      = active_s & instr_ready_i;
  end

`endif

endmodule

// File: tb/tb_bp_fe_realigner.sv
// Directed, table-driven bench for bp_fe_realigner in either BP_FE_COMPRESSED_EN build.
module tb_bp_fe_realigner;
  import bp_fe_pkg::*;

  localparam int VW = bp_vaddr_width_f(e_bp_default_cfg);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_v;
  logic [VW-1:0] fetch_pc;
  logic [31:0]   fetch_data;
  logic          fetch_ready;
  logic          redirect_v;
  logic          instr_v;
  logic [31:0]   instr;
  logic [VW-1:0] instr_pc;
  logic          instr_compressed;
  logic          instr_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          v;
    logic [VW-1:0] pc;
    logic [31:0]   data;
    logic          redir;
    logic          rdy;
    logic          e_v;
    logic [31:0]   e_instr;
    logic [VW-1:0] e_pc;
    logic          e_c;
    logic          e_fr;
  } vec_t;

  vec_t vecs[$];

  bp_fe_realigner #(.bp_params_p(e_bp_default_cfg)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .fetch_v_i          (fetch_v),
    .fetch_pc_i         (fetch_pc),
    .fetch_data_i       (fetch_data),
    .fetch_ready_o      (fetch_ready),
    .redirect_v_i       (redirect_v),
    .instr_v_o          (instr_v),
    .instr_o            (instr),
    .instr_pc_o         (instr_pc),
    .instr_compressed_o (instr_compressed),
    .instr_ready_i      (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [63:0] pc, input logic [31:0] data,
                     input logic redir, input logic rdy, input logic e_v,
                     input logic [31:0] e_instr, input logic [63:0] e_pc,
                     input logic e_c, input logic e_fr);
    vec_t t;
    t.v = v; t.pc = VW'(pc); t.data = data; t.redir = redir; t.rdy = rdy;
    t.e_v = e_v; t.e_instr = e_instr; t.e_pc = VW'(e_pc); t.e_c = e_c; t.e_fr = e_fr;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] data,
                       input logic redir, input logic rdy);
    fetch_v = v; fetch_pc = VW'(pc); fetch_data = data; redirect_v = redir; instr_ready = rdy;
  endtask

  // Compare all outputs; payload fields only matter when an instruction is valid.
  task automatic chk_out(input string name, input logic e_v, input logic [31:0] e_instr,
                         input logic [63:0] e_pc, input logic e_c, input logic e_fr);
    chk({name, ".instr_v"}, 64'(instr_v), 64'(e_v));
    chk({name, ".fetch_ready"}, 64'(fetch_ready), 64'(e_fr));
    if (e_v) begin
      chk({name, ".instr"}, 64'(instr), 64'(e_instr));
      chk({name, ".pc"}, 64'(instr_pc), 64'(VW'(e_pc)));
      chk({name, ".compressed"}, 64'(instr_compressed), 64'(e_c));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 64'h1000, 32'h00A0_0093, 1'b0, 1'b1);
    #1;
    chk("reset.instr_v", 64'(instr_v), 64'd0);
    chk("reset.fetch_ready", 64'(fetch_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

`ifdef BP_FE_COMPRESSED_EN
    // v, pc, data, redir, rdy  ->  e_v, e_instr, e_pc, e_c, e_fr
    add(1'b1, 64'h1000, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h1000, 1'b0, 1'b1);
    add(1'b1, 64'h1000, 32'h4501_4501, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 64'h1000, 1'b1, 1'b1);
    add(1'b1, 64'h1004, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 64'h1002, 1'b1, 1'b0);
    add(1'b1, 64'h1004, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h1004, 1'b0, 1'b1);
    add(1'b1, 64'h2000, 32'h0093_4501, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 64'h2000, 1'b1, 1'b1);
    add(1'b1, 64'h2004, 32'h0000_00A0, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h2002, 1'b0, 1'b1);
    add(1'b0, 64'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 64'h2006, 1'b1, 1'b0);
    add(1'b1, 64'h4002, 32'h4501_0000, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 64'h4002, 1'b1, 1'b1);
    add(1'b1, 64'h4006, 32'h0093_0000, 1'b0, 1'b1, 1'b0, 32'h0,         64'h0,    1'b0, 1'b1);
    add(1'b1, 64'h4008, 32'h0093_00A0, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h4006, 1'b0, 1'b1);
    add(1'b1, 64'h5000, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h5000, 1'b0, 1'b1);
    add(1'b1, 64'h2000, 32'h0093_4501, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 64'h2000, 1'b1, 1'b1);
    add(1'b1, 64'h2004, 32'h0000_00A0, 1'b1, 1'b1, 1'b0, 32'h0,         64'h0,    1'b0, 1'b0);
    add(1'b1, 64'h3000, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h3000, 1'b0, 1'b1);
    add(1'b1, 64'h2000, 32'h0093_4501, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 64'h2000, 1'b1, 1'b1);
    add(1'b0, 64'h0,    32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         64'h0,    1'b0, 1'b0);
    add(1'b1, 64'h2004, 32'h0000_00A0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 64'h2004, 1'b1, 1'b1);
    add(1'b0, 64'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 64'h2006, 1'b1, 1'b0);
    add(1'b1, 64'h7F_FFFF_FFFE, 32'h0093_0000, 1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
    add(1'b1, 64'h0,    32'h0000_00A0, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h7F_FFFF_FFFE, 1'b0, 1'b1);
    add(1'b0, 64'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 64'h2,    1'b1, 1'b0);
    add(1'b0, 64'h0,    32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         64'h0,    1'b0, 1'b1);
`else
    add(1'b1, 64'h1000, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h1000, 1'b0, 1'b1);
    add(1'b1, 64'h1000, 32'h4501_4501, 1'b0, 1'b1, 1'b1, 32'h4501_4501, 64'h1000, 1'b0, 1'b1);
    add(1'b1, 64'h1002, 32'h4501_4501, 1'b0, 1'b1, 1'b0, 32'h0,         64'h0,    1'b0, 1'b1);
    add(1'b1, 64'h2000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 64'h2000, 1'b0, 1'b0);
    add(1'b0, 64'h0,    32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         64'h0,    1'b0, 1'b1);
    add(1'b1, 64'h7F_FFFF_FFFC, 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h00A0_0093, 64'h7F_FFFF_FFFC, 1'b0, 1'b1);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, 64'(vecs[i].pc), vecs[i].data, vecs[i].redir, vecs[i].rdy);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_instr, 64'(vecs[i].e_pc),
              vecs[i].e_c, vecs[i].e_fr);
    end

    // Consumer stall: word held, outputs frozen, then accepted on first ready cycle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 64'h6000, 32'h00A0_0093, 1'b0, 1'b0);
      #1;
      chk_out($sformatf("stall%0d", c), 1'b1, 32'h00A0_0093, 64'h6000, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 64'h6000, 32'h00A0_0093, 1'b0, 1'b1);
    #1;
    chk_out("stall_release", 1'b1, 32'h00A0_0093, 64'h6000, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk_out("stall_after", 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);

`ifdef BP_FE_COMPRESSED_EN
    // Pending parcel survives a stalled consumer.
    @(negedge clk);
    drive(1'b1, 64'h7000, 32'h4501_4501, 1'b0, 1'b1);
    #1;
    chk_out("pstall_first", 1'b1, 32'h0000_4501, 64'h7000, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_out($sformatf("pstall%0d", c), 1'b1, 32'h0000_4501, 64'h7002, 1'b1, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk_out("pstall_hs", 1'b1, 32'h0000_4501, 64'h7002, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk_out("pstall_done", 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);

    // Asynchronous reset while a parcel is pending.
    @(negedge clk);
    drive(1'b1, 64'h8000, 32'h4501_4501, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk_out("rst_pending", 1'b1, 32'h0000_4501, 64'h8002, 1'b1, 1'b0);
`else
    @(negedge clk);
    drive(1'b1, 64'h8000, 32'h00A0_0093, 1'b0, 1'b1);
    #1;
    chk_out("rst_before", 1'b1, 32'h00A0_0093, 64'h8000, 1'b0, 1'b1);
`endif
    #1;
    reset_n = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk_out("rst_idle", 1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 64'h9000, 32'h00A0_0093, 1'b0, 1'b1);
    #1;
    chk_out("rst_first", 1'b1, 32'h00A0_0093, 64'h9000, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
